// File: rtl/sqrt_bus_initiator.sv
// sqrt_bus_initiator
// ------------------
// Bus-side initiator for the shift-subtract square-root core on the femtoRV
// peripheral bus. The CPU writes a radicand, pulses START, and polls STATUS
// until DONE. The block issues a one-cycle sq_init to the core, waits for
// the core's one-cycle sq_done, and then captures the root into RESULT.
//
// Register map (byte offsets):
//   0x00 RADICAND  R/W  bits[WIDTH-1:0]
//   0x04 CTRL      W    bit0 START
//   0x08 STATUS    R    bit0 BUSY, bit1 DONE (W1C), bit2 TIMEOUT (W1C)
//   0x0C RESULT    R    bits[WIDTH/2-1:0], zero-extended
//   other offsets read 0, and writes to them are ignored.
//
// Optional feature: define SQRT_TIMEOUT_EN to abort a run after
// TIMEOUT_CYCLES cycles in WAIT. The abort sets TIMEOUT and forces RESULT to
// all ones. Without the macro, WAIT waits indefinitely and STATUS bit2 is 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cs, rd, wr    chip select, read strobe, write strobe
//   addr, d_in    byte offset and write data
//   d_out         registered read data (one-cycle latency)
//   sq_radicand   radicand presented to the core
//   sq_init       one-cycle start pulse to the core
//   sq_done       one-cycle completion pulse from the core
//   sq_result     root from the core, valid while sq_done is high
//
// State | meaning
// ------+--------------------------------------------------
// IDLE  | not busy; accepts START
// LAUNCH| sq_init high for this single cycle
// WAIT  | busy; waits for sq_done (or the timeout)
module sqrt_bus_initiator #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [4:0]           addr,
    input  logic [31:0]          d_in,
    output logic [31:0]          d_out,
    output logic [WIDTH-1:0]     sq_radicand,
    output logic                 sq_init,
    input  logic                 sq_done,
    input  logic [WIDTH/2-1:0]   sq_result
);

    localparam int RW = WIDTH / 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [4:0] A_RADICAND = 5'h00;
    localparam logic [4:0] A_CTRL     = 5'h04;
    localparam logic [4:0] A_STATUS   = 5'h08;
    localparam logic [4:0] A_RESULT   = 5'h0C;

    logic [1:0]       state;
    logic [WIDTH-1:0] radicand_q;
    logic [RW-1:0]    result_q;
    logic             done_q;
    logic             timeout_q;
    logic             busy;
    logic             wr_en;
    logic             rd_en;
    logic             start_wr;
    logic             status_wr;
    logic             done_hit;
    logic             timeout_hit;
    logic [31:0]      rd_data;

    assign busy      = (state != S_IDLE);
    assign wr_en     = cs & wr;
    assign rd_en     = cs & rd;
    assign start_wr  = wr_en && (addr == A_CTRL) && d_in[0] && (state == S_IDLE);
    assign status_wr = wr_en && (addr == A_STATUS);
    // sq_done outside WAIT belongs to no run of ours and is dropped.
    assign done_hit  = (state == S_WAIT) && sq_done;

    assign sq_init     = (state == S_LAUNCH);
    assign sq_radicand = radicand_q;

`ifdef SQRT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Cleared in LAUNCH so it starts from zero on entry to WAIT. The abort
    // fires in the WAIT cycle whose increment brings the count to
    // TIMEOUT_CYCLES. A coincident sq_done takes priority over it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && !sq_done &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end else if (start_wr || (status_wr && d_in[2])) begin
            timeout_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_q   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start_wr) state <= S_LAUNCH;
                S_LAUNCH: state <= S_WAIT;
                S_WAIT:   if (done_hit || timeout_hit) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // The radicand is frozen while busy so the core sees a stable operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            radicand_q <= '0;
        end else if (wr_en && (addr == A_RADICAND) && !busy) begin
            radicand_q <= d_in[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (done_hit) begin
            result_q <= sq_result;
        end else if (timeout_hit) begin
            result_q <= '1;
        end
    end

    // A set outranks a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (done_hit) begin
            done_q <= 1'b1;
        end else if (start_wr || (status_wr && d_in[1])) begin
            done_q <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            A_RADICAND: rd_data = 32'(radicand_q);
            A_STATUS:   rd_data = {29'd0, timeout_q, done_q, busy};
            A_RESULT:   rd_data = 32'(result_q);
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_sqrt_bus_initiator.sv
// Testbench for sqrt_bus_initiator. Acts as the CPU on the bus and as a stub
// sqrt core. Expected register contents come from a small model: the last
// radicand accepted, plus integer square roots computed by plain search.
module tb_sqrt_bus_initiator;

    localparam int WIDTH = 16;
    localparam int RW    = WIDTH / 2;
    localparam int TO    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs = 1'b0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [4:0]        addr = '0;
    logic [31:0]       d_in = '0;
    logic [31:0]       d_out;
    logic [WIDTH-1:0]  sq_radicand;
    logic              sq_init;
    logic              sq_done = 1'b0;
    logic [RW-1:0]     sq_result = '0;

    int errors = 0;
    int checks = 0;
    int init_pulses = 0;
    int pulses_at_start = 0;

    logic [WIDTH-1:0]  m_rad = '0;
    logic [RW-1:0]     m_res = '0;

    sqrt_bus_initiator #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
        .d_in(d_in), .d_out(d_out), .sq_radicand(sq_radicand),
        .sq_init(sq_init), .sq_done(sq_done), .sq_result(sq_result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sq_init) init_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = $urandom;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    // Stub core: answers from whatever radicand the DUT is presenting now.
    task automatic core_respond();
        sq_done = 1'b1;
        sq_result = RW'(isqrt(int'(sq_radicand)));
        @(negedge clk);
        sq_done = 1'b0;
        sq_result = RW'($urandom);
    endtask

    // Loads a radicand and starts a run. Returns at the first WAIT cycle.
    // With glitch set, a stray sq_done is also driven during LAUNCH.
    task automatic start_run(input logic [WIDTH-1:0] n, input bit glitch);
        logic [31:0] v;
        bus_write(5'h00, 32'(n));
        m_rad = n;
        checks++;
        if (sq_radicand !== m_rad) begin
            errors++;
            $display("FAIL radicand_out: got %0h expected %0h", sq_radicand, m_rad);
        end
        pulses_at_start = init_pulses;
        v = $urandom;
        v[0] = 1'b1;
        bus_write(5'h04, v);
        checks++;
        if (sq_init !== 1'b1) begin
            errors++;
            $display("FAIL init_pulse_high: got %0b expected 1", sq_init);
        end
        if (glitch) begin
            sq_done = 1'b1;
            sq_result = RW'($urandom);
        end
        @(negedge clk);
        sq_done = 1'b0;
        checks++;
        if (sq_init !== 1'b0) begin
            errors++;
            $display("FAIL init_pulse_low: got %0b expected 0", sq_init);
        end
    endtask

    task automatic finish_run(input int lat);
        logic [31:0] d;
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL status_busy: got %0h expected 1", d);
        end
        repeat (lat) @(negedge clk);
        core_respond();
        m_res = RW'(isqrt(int'(m_rad)));
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL status_done: got %0h expected 2", d);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'(m_res)) begin
            errors++;
            $display("FAIL result rad=%0d: got %0d expected %0d", m_rad, d, m_res);
        end
        checks++;
        if (init_pulses - pulses_at_start !== 1) begin
            errors++;
            $display("FAIL init_count: got %0d expected 1", init_pulses - pulses_at_start);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sq_init, sq_radicand, d_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got init=%0b rad=%0h dout=%0h expected 0",
                     sq_init, sq_radicand, d_out);
        end
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %0h expected 0", d);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %0h expected 0", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        start_run(16'd144, 1'b0);
        finish_run(3);
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'd12) begin
            errors++;
            $display("FAIL basic_144: got %0d expected 12", d);
        end
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'd144) begin
            errors++;
            $display("FAIL radicand_readback: got %0d expected 144", d);
        end
    endtask

    task automatic test_extremes();
        start_run(16'hFFFF, 1'b0);
        finish_run(0);
        start_run(16'h0000, 1'b0);
        finish_run(5);
    endtask

    task automatic test_random();
        logic [31:0] n;
        for (int i = 0; i < 8; i++) begin
            n = $urandom;
            start_run(n[WIDTH-1:0], 1'b0);
            finish_run(int'($urandom_range(0, 12)));
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        logic [WIDTH-1:0] r0;
        int p;
        r0 = WIDTH'($urandom_range(100, 60000));
        start_run(r0, 1'b0);
        p = init_pulses;
        bus_write(5'h00, 32'd49);
        bus_write(5'h04, 32'd1);
        checks++;
        if (sq_radicand !== r0) begin
            errors++;
            $display("FAIL busy_radicand: got %0d expected %0d", sq_radicand, r0);
        end
        checks++;
        if (init_pulses !== p) begin
            errors++;
            $display("FAIL busy_start: got %0d pulses expected %0d", init_pulses, p);
        end
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'(r0)) begin
            errors++;
            $display("FAIL busy_readback: got %0d expected %0d", d, r0);
        end
        finish_run(2);
    endtask

    task automatic test_ignored_done();
        logic [31:0] d;
        sq_done = 1'b1;
        sq_result = ~m_res;
        @(negedge clk);
        sq_done = 1'b0;
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL idle_done_status: got %0h expected 2", d);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'(m_res)) begin
            errors++;
            $display("FAIL idle_done_result: got %0h expected %0h", d, m_res);
        end
        start_run(WIDTH'($urandom_range(1, 65535)), 1'b1);
        finish_run(4);
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        start_run(WIDTH'($urandom_range(1, 65535)), 1'b0);
        repeat (2) @(negedge clk);
        sq_done = 1'b1;
        sq_result = RW'(isqrt(int'(sq_radicand)));
        cs = 1'b1; wr = 1'b1; addr = 5'h08; d_in = 32'h2;
        @(negedge clk);
        sq_done = 1'b0; cs = 1'b0; wr = 1'b0;
        m_res = RW'(isqrt(int'(m_rad)));
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL race_set_wins: got %0h expected 2", d);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'(m_res)) begin
            errors++;
            $display("FAIL race_result: got %0h expected %0h", d, m_res);
        end
        bus_write(5'h08, 32'h2);
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_clear: got %0h expected 0", d);
        end
    endtask

    task automatic test_other_offsets();
        logic [31:0] d;
        bus_write(5'h10, $urandom);
        bus_write(5'h14, $urandom);
        bus_read(5'h00, d);
        checks++;
        if (d !== 32'(m_rad)) begin
            errors++;
            $display("FAIL stray_write: got %0h expected %0h", d, m_rad);
        end
        bus_read(5'h10, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %0h expected 0", d);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int busy_cnt;
        logic [31:0] last;
        start_run(WIDTH'($urandom_range(1, 65535)), 1'b0);
        cs = 1'b1; rd = 1'b1; addr = 5'h08;
        busy_cnt = 0;
        last = 32'h1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            last = d_out;
            if (last !== 32'h1) break;
            busy_cnt++;
        end
        cs = 1'b0; rd = 1'b0;
`ifdef SQRT_TIMEOUT_EN
        checks++;
        if (busy_cnt !== TO || last !== 32'h4) begin
            errors++;
            $display("FAIL timeout_timing: got %0d busy cycles then %0h expected %0d then 4",
                     busy_cnt, last, TO);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'hFF) begin
            errors++;
            $display("FAIL timeout_result: got %0h expected ff", d);
        end
`else
        checks++;
        if (busy_cnt !== 300) begin
            errors++;
            $display("FAIL no_timeout: got %0d busy cycles (then %0h) expected 300",
                     busy_cnt, last);
        end
        finish_run(0);
        d = 32'h0;
`endif
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        start_run(WIDTH'($urandom_range(1, 65535)), 1'b0);
        bus_read(5'h08, d);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rad = '0;
        m_res = '0;
        checks++;
        if ({sq_init, sq_radicand, d_out} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got init=%0b rad=%0h dout=%0h expected 0",
                     sq_init, sq_radicand, d_out);
        end
        sq_done = 1'b1;
        sq_result = RW'($urandom_range(1, 255));
        @(negedge clk);
        sq_done = 1'b0;
        bus_read(5'h08, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midrun_status: got %0h expected 0", d);
        end
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midrun_result: got %0h expected 0", d);
        end
        start_run(16'd81, 1'b0);
        finish_run(4);
        bus_read(5'h0C, d);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL restart_81: got %0d expected 9", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_busy_writes();
        test_ignored_done();
        test_w1c_race();
        test_other_offsets();
        test_timeout();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
